vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_pkg.sv | 43 ++++
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen_pixel_tick.sv | 44 ++++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : vga_pkg                                                         |
// | Purpose  : Shared 640x480@60 Hz timing constants, coordinate type and the  |
// |            colour constants used by the downstream colour stage.           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vga_pkg;

  // Coordinate width covers totals up to 1024
  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // 640x480@60 Hz reference timing
  localparam int unsigned H_ACTIVE_640 = 640;
  localparam int unsigned H_FP_640     = 16;
  localparam int unsigned H_SYNC_640   = 96;
  localparam int unsigned H_BP_640     = 48;
  localparam int unsigned V_ACTIVE_480 = 480;
  localparam int unsigned V_FP_480     = 10;
  localparam int unsigned V_SYNC_480   = 2;
  localparam int unsigned V_BP_480     = 33;

  localparam int unsigned H_TOTAL_640 = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;
  localparam int unsigned V_TOTAL_480 = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

  // Colour stage constants (4:4:4 RGB)
  localparam int unsigned COLOR_W = 12;
  typedef logic [COLOR_W-1:0] color_t;
  localparam color_t COLOR_BLACK = 12'h000;
  localparam color_t COLOR_WHITE = 12'hFFF;

  // Half-open window test: lo <= val < hi. Done at 32 bits so an upper
  // bound equal to 1024 does not wrap.
  function automatic logic in_range(input int unsigned val,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : vga_timing_gen_if                                              |
// | Purpose   : Raster timing bundle from the timing generator to the colour   |
// |             stage.                                                         |
// | Signals   : pixel_tick   - one-clock pulse per pixel period                |
// |             current_row  - horizontal position (x)                         |
// |             current_line - vertical position (y)                           |
// |             enable       - active-video window                             |
// |             hsync/vsync  - delayed sync outputs                            |
// |             frame_start  - one-clock pulse at position (0,0)               |
// | Modports  : master (generator drives), slave (consumer reads)              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pixel_tick;
  coord_t current_row;
  coord_t current_line;
  logic   enable;
  logic   hsync;
  logic   vsync;
  logic   frame_start;

  modport master (
    output pixel_tick, current_row, current_line, enable, hsync, vsync, frame_start
  );

  modport slave (
    input  pixel_tick, current_row, current_line, enable, hsync, vsync, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_pixel_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pixel_tick                                                  |
// | Purpose  : Clock-enable divider. Emits a registered one-cycle pulse every  |
// |            CLK_DIV clk_in cycles; with CLK_DIV=1 the pulse is constant.    |
// | Ports    : clk_in  - system clock                                          |
// |            rst_n   - synchronous active-low reset                          |
// |            o_tick  - pixel-rate enable pulse                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic o_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;

  // The tick is registered, so it appears the cycle after the count hits
  // its last value; the first tick after reset lands CLK_DIV edges later.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= (r_div_cnt == C_DIV_LAST);
      if (r_div_cnt == C_DIV_LAST) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                  |
// | Purpose  : VGA raster timing: pixel-rate divider, horizontal/vertical      |
// |            counters, active-video/sync decode and a sync delay line that   |
// |            aligns hsync/vsync with the colour stage's registered output.   |
// | Ports    : clk_in  - system clock                                          |
// |            rst_n   - synchronous active-low reset                          |
// |            bus     - vga_timing_gen_if.master (tick, coordinates, enable,  |
// |                      hsync, vsync, frame_start)                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_640,
  parameter int unsigned H_FP       = H_FP_640,
  parameter int unsigned H_SYNC     = H_SYNC_640,
  parameter int unsigned H_BP       = H_BP_640,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_480,
  parameter int unsigned V_FP       = V_FP_480,
  parameter int unsigned V_SYNC     = V_SYNC_480,
  parameter int unsigned V_BP       = V_BP_480,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam coord_t C_H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t C_V_LAST = coord_t'(V_TOTAL - 1);

  logic   w_tick;
  coord_t r_h, r_v;
  coord_t w_h_nxt, w_v_nxt;
  logic   w_en_nxt, w_hs_nxt, w_vs_nxt, w_fs_nxt;

  coord_t r_row, r_line;
  logic   r_en, r_fs;
  logic   r_hs_raw, r_vs_raw;
  logic   w_hsync, w_vsync;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .o_tick  (w_tick)
  );

  // Position the counters will take on the next tick
  always_comb begin
    w_h_nxt = r_h + 1'b1;
    w_v_nxt = r_v;
    if (r_h == C_H_LAST) begin
      w_h_nxt = '0;
      if (r_v == C_V_LAST) begin
        w_v_nxt = '0;
      end else begin
        w_v_nxt = r_v + 1'b1;
      end
    end
  end

  // Decode from the new position so outputs change on the same edge as the counters
  always_comb begin
    w_en_nxt = (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
    w_hs_nxt = in_range(32'(w_h_nxt), HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    w_vs_nxt = in_range(32'(w_v_nxt), VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    w_fs_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
  end

  // Counters start at the last position so the first tick steps onto (0,0);
  // the visible coordinate registers start at 0, hence the separate copies.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_h      <= C_H_LAST;
      r_v      <= C_V_LAST;
      r_row    <= '0;
      r_line   <= '0;
      r_en     <= 1'b0;
      r_fs     <= 1'b0;
      r_hs_raw <= ~SYNC_POL;
      r_vs_raw <= ~SYNC_POL;
    end else begin
      r_fs <= 1'b0;
      if (w_tick) begin
        r_h      <= w_h_nxt;
        r_v      <= w_v_nxt;
        r_row    <= w_h_nxt;
        r_line   <= w_v_nxt;
        r_en     <= w_en_nxt;
        r_fs     <= w_fs_nxt;
        r_hs_raw <= w_hs_nxt;
        r_vs_raw <= w_vs_nxt;
      end
    end
  end

  // Sync delay line runs at clk_in rate, independent of the pixel tick
  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign w_hsync = r_hs_raw;
      assign w_vsync = r_vs_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] r_hs_dly;
      logic [SYNC_DELAY-1:0] r_vs_dly;

      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          r_hs_dly <= {SYNC_DELAY{~SYNC_POL}};
          r_vs_dly <= {SYNC_DELAY{~SYNC_POL}};
        end else begin
          r_hs_dly[0] <= r_hs_raw;
          r_vs_dly[0] <= r_vs_raw;
          for (int i = 1; i < int'(SYNC_DELAY); i++) begin
            r_hs_dly[i] <= r_hs_dly[i-1];
            r_vs_dly[i] <= r_vs_dly[i-1];
          end
        end
      end

      assign w_hsync = r_hs_dly[SYNC_DELAY-1];
      assign w_vsync = r_vs_dly[SYNC_DELAY-1];
    end
  endgenerate

  assign bus.pixel_tick   = w_tick;
  assign bus.current_row  = r_row;
  assign bus.current_line = r_line;
  assign bus.enable       = r_en;
  assign bus.frame_start  = r_fs;
  assign bus.hsync        = w_hsync;
  assign bus.vsync        = w_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                               |
// | Purpose  : Directed self-checking bench for vga_timing_gen. Four instances:|
// |            a: default 640x480, CLK_DIV=4, SYNC_DELAY=1                     |
// |            b: default geometry, CLK_DIV=1, SYNC_DELAY=0                    |
// |            c: default geometry, CLK_DIV=1, SYNC_DELAY=2 (shares b's reset) |
// |            s: 15x13 raster, CLK_DIV=2, SYNC_DELAY=1, SYNC_POL=1            |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_s;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();
  vga_timing_gen_if if_s ();

  vga_timing_gen #(.CLK_DIV(4), .SYNC_DELAY(1)) dut_a (
    .clk_in(clk), .rst_n(rst_a), .bus(if_a));
  vga_timing_gen #(.CLK_DIV(1), .SYNC_DELAY(0)) dut_b (
    .clk_in(clk), .rst_n(rst_b), .bus(if_b));
  vga_timing_gen #(.CLK_DIV(1), .SYNC_DELAY(2)) dut_c (
    .clk_in(clk), .rst_n(rst_b), .bus(if_c));
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .SYNC_POL(1'b1), .SYNC_DELAY(1)) dut_s (
    .clk_in(clk), .rst_n(rst_s), .bus(if_s));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and sample away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int bad_row, bad_line, bad_en, bad_hs, bad_vs, bad_tick, bad_fs;
  int hs_low, hs_first, en_fall, found;
  int er, el, ee, eh, ev, k;
  int b_row656, b_hs_fall, c_hs_fall, c_hs_rise;
  int fs_cnt, fs0, fs1, vs_cnt;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_s = 1'b0;
    repeat (10) step();

    // ---------------- reset state ----------------
    check_val("a_rst_tick",  if_a.pixel_tick,   0);
    check_val("a_rst_row",   if_a.current_row,  0);
    check_val("a_rst_line",  if_a.current_line, 0);
    check_val("a_rst_en",    if_a.enable,       0);
    check_val("a_rst_fs",    if_a.frame_start,  0);
    check_val("a_rst_hs",    if_a.hsync,        1);
    check_val("a_rst_vs",    if_a.vsync,        1);
    check_val("s_rst_hs",    if_s.hsync,        0);
    check_val("s_rst_vs",    if_s.vsync,        0);

    // ---------------- release, first tick at cycle 4 ----------------
    rst_a = 1'b1;
    bad_tick = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (if_a.pixel_tick !== 1'b0) bad_tick++;
    end
    check_val("a_tick_early", bad_tick, 0);
    step();
    check_val("a_tick_c4", if_a.pixel_tick, 1);
    check_val("a_en_pre",  if_a.enable,     0);
    step();
    check_val("a_first_row",  if_a.current_row,  0);
    check_val("a_first_line", if_a.current_line, 0);
    check_val("a_first_en",   if_a.enable,       1);
    check_val("a_first_fs",   if_a.frame_start,  1);
    check_val("a_first_tick", if_a.pixel_tick,   0);
    step();
    check_val("a_fs_pulse", if_a.frame_start, 0);

    // ---------------- one full line plus wrap (sampled 1 clk after update) ----------------
    bad_row = 0; bad_line = 0; bad_en = 0; bad_hs = 0; bad_vs = 0;
    hs_low = 0; hs_first = -1; en_fall = -1;
    for (int p = 0; p <= 800; p++) begin
      if (p > 0) repeat (4) step();
      er = p % 800;
      el = p / 800;
      ee = (er < 640) ? 1 : 0;
      eh = (er >= 656 && er < 752) ? 0 : 1;
      if (if_a.current_row  !== 10'(er)) bad_row++;
      if (if_a.current_line !== 10'(el)) bad_line++;
      if (if_a.enable       !== ee[0])   bad_en++;
      if (if_a.hsync        !== eh[0])   bad_hs++;
      if (if_a.vsync        !== 1'b1)    bad_vs++;
      if (p < 800 && if_a.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(if_a.current_row);
      end
      if (p < 800 && en_fall < 0 && if_a.enable === 1'b0) en_fall = int'(if_a.current_row);
    end
    check_val("a_row_seq",  bad_row,  0);
    check_val("a_line_seq", bad_line, 0);
    check_val("a_en_seq",   bad_en,   0);
    check_val("a_hs_seq",   bad_hs,   0);
    check_val("a_vs_seq",   bad_vs,   0);
    check_val("a_hs_width", hs_low,   96);
    check_val("a_hs_first", hs_first, 656);
    check_val("a_en_fall",  en_fall,  640);
    check_val("a_wrap_row",  if_a.current_row,  0);
    check_val("a_wrap_line", if_a.current_line, 1);

    // ---------------- mid-frame reset on a ----------------
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      step();
      if (if_a.current_row == 10'd300 && if_a.current_line == 10'd1) found = 1;
    end
    check_val("a_mid_wait", found, 1);
    rst_a = 1'b0;
    step();
    check_val("a_mid_tick", if_a.pixel_tick,   0);
    check_val("a_mid_row",  if_a.current_row,  0);
    check_val("a_mid_line", if_a.current_line, 0);
    check_val("a_mid_en",   if_a.enable,       0);
    check_val("a_mid_fs",   if_a.frame_start,  0);
    rst_a = 1'b1;
    repeat (3) step();
    check_val("a_re_tick_early", if_a.pixel_tick, 0);
    step();
    check_val("a_re_tick", if_a.pixel_tick, 1);
    step();
    check_val("a_re_row",  if_a.current_row,  0);
    check_val("a_re_line", if_a.current_line, 0);
    check_val("a_re_en",   if_a.enable,       1);
    check_val("a_re_fs",   if_a.frame_start,  1);

    // ---------------- CLK_DIV=1 and sync alignment (b: delay 0, c: delay 2) ----------------
    rst_b = 1'b1;
    bad_tick = 0; bad_row = 0; bad_fs = 0;
    b_row656 = -1; b_hs_fall = -1; c_hs_fall = -1; c_hs_rise = -1;
    for (int c = 0; c < 900; c++) begin
      step();
      er = (c == 0) ? 0 : (c - 1) % 800;
      el = (c == 0) ? 0 : (c - 1) / 800;
      if (if_b.pixel_tick !== 1'b1) bad_tick++;
      if (if_b.current_row !== 10'(er) || if_b.current_line !== 10'(el)) bad_row++;
      if (if_b.frame_start !== ((c == 1) ? 1'b1 : 1'b0)) bad_fs++;
      if (b_row656 < 0 && if_b.current_row == 10'd656) b_row656 = c;
      if (b_hs_fall < 0 && if_b.hsync === 1'b0) b_hs_fall = c;
      if (c_hs_fall < 0 && if_c.hsync === 1'b0) c_hs_fall = c;
      if (c_hs_fall >= 0 && c_hs_rise < 0 && if_c.hsync === 1'b1) c_hs_rise = c;
    end
    check_val("b_tick_cont", bad_tick,  0);
    check_val("b_pos_seq",   bad_row,   0);
    check_val("b_fs_seq",    bad_fs,    0);
    check_val("b_row656",    b_row656,  657);
    check_val("b_hs_fall",   b_hs_fall, 657);
    check_val("c_hs_fall",   c_hs_fall, 659);
    check_val("c_hs_rise",   c_hs_rise, 755);

    // ---------------- small raster: full frames, vertical sync, frame period ----------------
    rst_s = 1'b1;
    bad_row = 0; bad_line = 0; bad_en = 0; bad_hs = 0; bad_vs = 0; bad_tick = 0;
    fs_cnt = 0; fs0 = -1; fs1 = -1; vs_cnt = 0; hs_low = 0;
    for (int c = 0; c <= 800; c++) begin
      step();
      if (if_s.pixel_tick !== ((c % 2 == 1) ? 1'b1 : 1'b0)) bad_tick++;
      if (if_s.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs0 < 0) fs0 = c;
        else if (fs1 < 0) fs1 = c;
      end
      if (c >= 3 && (c - 3) % 2 == 0) begin
        k  = (c - 3) / 2;
        er = k % 15;
        el = (k / 15) % 13;
        ee = (er < 8 && el < 6) ? 1 : 0;
        eh = (er >= 10 && er < 13) ? 1 : 0;
        ev = (el >= 8 && el < 10) ? 1 : 0;
        if (if_s.current_row  !== 10'(er)) bad_row++;
        if (if_s.current_line !== 10'(el)) bad_line++;
        if (if_s.enable !== ee[0]) bad_en++;
        if (if_s.hsync  !== eh[0]) bad_hs++;
        if (if_s.vsync  !== ev[0]) bad_vs++;
        if (k < 195 && if_s.vsync === 1'b1) vs_cnt++;
        if (k < 195 && if_s.hsync === 1'b1) hs_low++;
      end
    end
    check_val("s_tick_seq",  bad_tick, 0);
    check_val("s_row_seq",   bad_row,  0);
    check_val("s_line_seq",  bad_line, 0);
    check_val("s_en_seq",    bad_en,   0);
    check_val("s_hs_seq",    bad_hs,   0);
    check_val("s_vs_seq",    bad_vs,   0);
    check_val("s_vs_count",  vs_cnt,   30);
    check_val("s_hs_count",  hs_low,   39);
    check_val("s_fs_count",  fs_cnt,   3);
    check_val("s_fs_first",  fs0,      2);
    check_val("s_fs_period", fs1 - fs0, 390);

    // ---------------- mid-frame reset on s while both syncs are asserted ----------------
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      step();
      if (if_s.current_row == 10'd11 && if_s.current_line == 10'd8) found = 1;
    end
    check_val("s_mid_wait", found, 1);
    rst_s = 1'b0;
    step();
    check_val("s_mid_tick", if_s.pixel_tick,   0);
    check_val("s_mid_row",  if_s.current_row,  0);
    check_val("s_mid_line", if_s.current_line, 0);
    check_val("s_mid_en",   if_s.enable,       0);
    check_val("s_mid_hs",   if_s.hsync,        0);
    check_val("s_mid_vs",   if_s.vsync,        0);
    rst_s = 1'b1;
    step();
    check_val("s_re_tick_early", if_s.pixel_tick, 0);
    step();
    check_val("s_re_tick", if_s.pixel_tick, 1);
    step();
    check_val("s_re_row",  if_s.current_row,  0);
    check_val("s_re_line", if_s.current_line, 0);
    check_val("s_re_en",   if_s.enable,       1);
    check_val("s_re_fs",   if_s.frame_start,  1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
